// File: rtl/program_loader.sv
// Boot loader: receives a little-endian word count N followed by N
// little-endian 32-bit words over a UART byte stream, writes them into
// instruction memory, answers with an ACK/ERR byte and then releases the
// core from reset.
module program_loader #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rstn,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_ACK   = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Largest legal word count; 33 bits so the compare against a full
  // 32-bit header value cannot overflow.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;   // one extra bit so N == capacity does not wrap
  logic [ADDR_W:0]   n_words;
  logic [23:0]       asm_buf;    // bytes 0..2 of the word/header being assembled
  logic [23:0]       asm_nxt;
  logic [31:0]       full_word;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              hdr_too_big;

  // The 4th byte completes the word directly from rx_data, so a word is
  // available on the same edge its last byte is sampled.
  assign full_word    = {rx_data, asm_buf};
  assign word_cnt_inc = word_cnt + (ADDR_W + 1)'(1);
  assign hdr_too_big  = {1'b0, full_word} > CAPACITY;
  assign state_o      = state;

  // Drop the incoming byte into its slot of the assembly buffer.
  always_comb begin
    // NOTE: default assignment first so no path leaves asm_nxt unassigned
    // (otherwise a latch is inferred).
    asm_nxt = asm_buf;
    case (byte_cnt)
      2'd0:    asm_nxt[7:0]   = rx_data;
      2'd1:    asm_nxt[15:8]  = rx_data;
      2'd2:    asm_nxt[23:16] = rx_data;
      default: asm_nxt        = asm_buf;
    endcase
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_HDR;
      byte_cnt   <= 2'd0;
      word_cnt   <= '0;
      n_words    <= '0;
      asm_buf    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      core_rstn  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees
      // the pre-edge value of every other register.
      imem_we  <= 1'b0;
      tx_start <= 1'b0;

      case (state)
        S_HDR: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_buf  <= asm_nxt;
            if (byte_cnt == 2'd3) begin
              if (full_word == 32'd0) begin
                state <= S_ACK;
              end else if (hdr_too_big) begin
                state <= S_ERR;
              end else begin
                n_words  <= full_word[ADDR_W:0];
                word_cnt <= '0;
                state    <= S_LOAD;
              end
            end
          end
        end

        S_LOAD: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_buf  <= asm_nxt;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= full_word;
              state      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          // The write itself is on the bus this cycle; a byte arriving now
          // starts the next word.
          word_cnt <= word_cnt_inc;
          state    <= (word_cnt_inc == n_words) ? S_ACK : S_LOAD;
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_buf  <= asm_nxt;
          end
        end

        S_ACK: begin
          // One cycle of tx_start, then leave on the following edge.
          if (tx_start) begin
            core_rstn <= 1'b1;
            state     <= S_RUN;
          end else if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= ACK_BYTE;
          end
        end

        S_ERR: begin
          if (tx_start) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            n_words  <= '0;
            asm_buf  <= '0;
            state    <= S_HDR;
          end else if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= ERR_BYTE;
          end
        end

        S_RUN: begin
          core_rstn <= 1'b1;
        end

        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (ADDR_W=4, capacity 16 words).
// Expected memory writes and transmitted bytes are queued when stimulus is
// driven and popped by a negedge monitor when the DUT produces them.
module tb_program_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_busy = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rstn;
  logic [2:0]    state_o;

  program_loader #(.ADDR_W(AW), .ACK_BYTE(8'hAA), .ERR_BYTE(8'hEE)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] txq[$];
  wr_t        mon_e;
  logic [7:0] mon_b;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write and every tx pulse must match the head
  // of its queue, including the cycle on which the write appears.
  always @(negedge clk) begin
    if (imem_we) begin
      check("we_expected", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) begin
        mon_e = wq.pop_front();
        check("we_addr", 64'(imem_addr), 64'(mon_e.addr));
        check("we_data", 64'(imem_wdata), 64'(mon_e.data));
        check("we_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("we_state", 64'(state_o), 64'd2);
      end
    end
    if (tx_start) begin
      check("tx_expected", 64'(txq.size() > 0), 64'd1);
      if (txq.size() > 0) begin
        mon_b = txq.pop_front();
        check("tx_byte", 64'(tx_data), 64'(mon_b));
      end
    end
  end

  // One byte per call; consecutive calls give one byte per cycle.
  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic put_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) put(n[8*i +: 8]);
  endtask

  // Send a data word and expect its write on the cycle after the 4th byte.
  task automatic put_word(input logic [AW-1:0] addr, input logic [31:0] w);
    wr_t e;
    for (int i = 0; i < 4; i++) put(w[8*i +: 8]);
    e.addr = addr;
    e.data = w;
    e.cyc  = cyc;
    wq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},  64'(state_o),    64'd0);
    check({tag, "_we"},     64'(imem_we),    64'd0);
    check({tag, "_txs"},    64'(tx_start),   64'd0);
    check({tag, "_txd"},    64'(tx_data),    64'd0);
    check({tag, "_addr"},   64'(imem_addr),  64'd0);
    check({tag, "_wdata"},  64'(imem_wdata), 64'd0);
    check({tag, "_core"},   64'(core_rstn),  64'd0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_wq_left"},  64'(wq.size()),  64'd0);
    check({tag, "_txq_left"}, 64'(txq.size()), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs(tag);
    rstn = 1'b1;
    idle(1);
  endtask

  // Wait (bounded) for a tx pulse; check the state during the pulse and on
  // the following cycle.
  task automatic wait_tx(input string tag, input logic [7:0] b,
                         input logic [2:0] st_pulse, input logic [2:0] st_after,
                         input logic core_after);
    bit found = 1'b0;
    txq.push_back(b);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_start) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_tx_seen"}, 64'(found), 64'd1);
    if (found) begin
      check({tag, "_pulse_state"}, 64'(state_o), 64'(st_pulse));
      check({tag, "_pulse_core"}, 64'(core_rstn), 64'd0);
      @(negedge clk);
      check({tag, "_after_state"}, 64'(state_o), 64'(st_after));
      check({tag, "_after_txs"}, 64'(tx_start), 64'd0);
      check({tag, "_after_core"}, 64'(core_rstn), 64'(core_after));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_pulses;

    // Power-up reset.
    rstn = 1'b0;
    idle(2);
    check_reset_outputs("por");
    rstn = 1'b1;
    idle(1);

    // Two-word load, then ACK and core release.
    put_hdr(32'd2);
    check("load2_state_load", 64'(state_o), 64'd1);
    put_word(4'd0, 32'h1234_5678);
    idle(2);
    put_word(4'd1, 32'hDEAD_BEEF);
    wait_tx("load2", 8'hAA, 3'd3, 3'd4, 1'b1);
    check_drained("load2");

    // Zero-length load goes straight to ACK with no writes.
    do_reset("rst_a");
    put_hdr(32'd0);
    check("zero_state_ack", 64'(state_o), 64'd3);
    wait_tx("zero", 8'hAA, 3'd3, 3'd4, 1'b1);
    check_drained("zero");

    // Oversized header (17 > 16) is rejected; a valid load then works.
    do_reset("rst_b");
    put_hdr(32'd17);
    check("big_state_err", 64'(state_o), 64'd5);
    wait_tx("big", 8'hEE, 3'd5, 3'd0, 1'b0);
    put_hdr(32'd1);
    put_word(4'd0, 32'hCAFE_F00D);
    wait_tx("after_err", 8'hAA, 3'd3, 3'd4, 1'b1);
    check_drained("after_err");

    // tx_busy held high for 100 cycles in ACK.
    do_reset("rst_c");
    tx_busy = 1'b1;
    put_hdr(32'd0);
    busy_pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_start) busy_pulses++;
    end
    check("busy_no_start", 64'(busy_pulses), 64'd0);
    check("busy_state_ack", 64'(state_o), 64'd3);
    check("busy_txd_held", 64'(tx_data), 64'd0);
    @(posedge clk);
    #1;
    tx_busy = 1'b0;
    wait_tx("busy", 8'hAA, 3'd3, 3'd4, 1'b1);
    check_drained("busy");

    // Full-capacity load (N == 16), header and all data back-to-back, so
    // byte 0 of each word lands in the WRITE cycle.
    do_reset("rst_d");
    put_hdr(32'd16);
    for (int i = 0; i < 16; i++)
      put_word(4'(i), 32'hA5000000 ^ (32'(i) * 32'h0103_0507));
    wait_tx("full", 8'hAA, 3'd3, 3'd4, 1'b1);
    check_drained("full");

    // Reset mid-load discards the partial word.
    do_reset("rst_e");
    put_hdr(32'd2);
    put_word(4'd0, 32'h0102_0304);
    put(8'h55);
    put(8'h66);
    rstn = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
    put_hdr(32'd1);
    check("fresh_state_load", 64'(state_o), 64'd1);
    put_word(4'd0, 32'h1122_3344);
    wait_tx("fresh", 8'hAA, 3'd3, 3'd4, 1'b1);
    // Bytes received in RUN are ignored.
    for (int i = 0; i < 8; i++) put(8'(8'h90 + i));
    idle(3);
    check("run_state_held", 64'(state_o), 64'd4);
    check("run_core_held", 64'(core_rstn), 64'd1);
    check("run_wdata_held", 64'(imem_wdata), 64'h1122_3344);
    check_drained("fresh");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 14: instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 Parameter ACK_BYTE, default 8'hAA: byte sent after a successful load.
REQ-003 Parameter ERR_BYTE, default 8'hEE: byte sent when the load is rejected.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 rx_data  input  8  byte from the UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid when high.
REQ-008 tx_data  output  8  byte to the UART transmitter.
REQ-009 tx_start  output  1  one-cycle strobe requesting transmission of tx_data.
REQ-010 tx_busy  input  1  transmitter busy; high = transmitter cannot accept a byte.
REQ-011 imem_we  output  1  instruction-memory write enable.
REQ-012 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-013 imem_wdata  output  32  instruction-memory write data.
REQ-014 core_rstn  output  1  core reset, active-low; high = core runs.
REQ-015 state_o  output  3  current state encoding, for LED display.

Function
REQ-016 States SHALL be encoded as follows: HDR=0, LOAD=1, WRITE=2, ACK=3, RUN=4, ERR=5.
REQ-017 HDR: four rx_valid bytes SHALL form a 32-bit word count N, little-endian (first byte = bits 7:0).
REQ-018 On the 4th header byte, if N == 0, the next state SHALL be ACK.
REQ-019 On the 4th header byte, if N > 2^ADDR_W, the next state SHALL be ERR.
REQ-020 On the 4th header byte, otherwise, the next state SHALL be LOAD with the word counter cleared to 0.
REQ-021 LOAD: each group of four rx_valid bytes SHALL be assembled into one little-endian 32-bit word.
REQ-022 On the 4th byte of a word, the next state SHALL be WRITE.
REQ-023 WRITE: lasts exactly one cycle; imem_we=1, imem_addr=word counter, imem_wdata=assembled word.
REQ-024 WRITE exit: word counter SHALL increment; next state = ACK if the incremented count equals N, else LOAD.
REQ-025 Write latency: imem_we SHALL assert exactly one cycle after the rx_valid carrying the word's 4th byte.
REQ-026 An rx_valid that arrives during WRITE SHALL be accepted as byte 0 of the next word and SHALL NOT be lost.
REQ-027 ACK: when tx_busy==0, tx_start SHALL pulse for one cycle with tx_data=ACK_BYTE, then the next state SHALL be RUN.
REQ-028 ACK: tx_start SHALL stay low while tx_busy==1, and tx_data SHALL hold its value.
REQ-029 RUN: core_rstn=1, held until reset; every rx_valid SHALL be ignored.
REQ-030 ERR: send ERR_BYTE under the same tx_busy rule as ACK, then return to HDR with all counters cleared.
REQ-031 In ACK and ERR, rx_valid SHALL be ignored.
REQ-032 The byte counter is 2 bits and SHALL wrap 3->0 at each completed word or header.
REQ-033 The word counter is ADDR_W+1 bits, so that N == 2^ADDR_W does not wrap.
REQ-034 imem_addr SHALL never exceed 2^ADDR_W-1.
REQ-035 core_rstn SHALL be 0 in every state except RUN.
REQ-036 imem_we and tx_start SHALL be 0 in every state other than those stated above.

Reset
REQ-037 rstn low SHALL, asynchronously, force: state HDR, all counters 0, imem_we=0, tx_start=0, tx_data=0, imem_addr=0, imem_wdata=0, core_rstn=0, state_o=0.
REQ-038 Reset asserted mid-LOAD SHALL discard the partial word.
REQ-039 After a mid-LOAD reset, the next received byte SHALL be treated as header byte 0.

Verification
REQ-040 Header 02 00 00 00, words 78 56 34 12 and EF BE AD DE -> imem writes addr0=0x12345678 and addr1=0xDEADBEEF; tx 0xAA; core_rstn rises after the tx_start pulse.
REQ-041 Header 00 00 00 00 -> no imem_we; tx 0xAA; RUN.
REQ-042 With ADDR_W=4, header 11 00 00 00 (N=17) -> tx 0xEE; back in HDR; a following valid load succeeds.
REQ-043 tx_busy held high for 100 cycles in ACK -> tx_start stays low throughout, then pulses once after tx_busy falls.
REQ-044 rx_valid in the WRITE cycle, back-to-back bytes at one per cycle -> all words written correctly; imem_we exactly one cycle after each 4th byte.
REQ-045 rstn pulsed low after 2 bytes of word 1 -> outputs at reset values immediately; a fresh header loads correctly; bytes after RUN do not alter memory.
